// File: rtl/clock_mode_ctrl_if.sv
// Key/tick/time inputs and the enable/alarm/mode outputs of clock_mode_ctrl.
// Scalar clock and reset are carried on the module ports, not in this bundle.
interface clock_mode_ctrl_if;
  logic       tick_1hz;
  logic       key_mode;
  logic       key_next;
  logic       key_inc;
  logic       key_stop;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       inc_h;
  logic       inc_m;
  logic       inc_s;
  logic       clr_s;
  logic [7:0] alm_hour;
  logic [7:0] alm_minute;
  logic       alm_en;
  logic       alert;
  logic [2:0] state;

  modport master (
    output tick_1hz, key_mode, key_next, key_inc, key_stop, hour, minute, second,
    input  inc_h, inc_m, inc_s, clr_s, alm_hour, alm_minute, alm_en, alert, state
  );
  modport slave (
    input  tick_1hz, key_mode, key_next, key_inc, key_stop, hour, minute, second,
    output inc_h, inc_m, inc_s, clr_s, alm_hour, alm_minute, alm_en, alert, state
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode/sequence controller for the digital clock: key decode, tick gating,
// count enables to the counter chain, BCD alarm registers and alert scheduling.
module clock_mode_ctrl #(
  parameter int unsigned RING_SECS  = 60,
  parameter logic [7:0]  ALM_H_INIT = 8'h07,
  parameter logic [7:0]  ALM_M_INIT = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  clock_mode_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2, SET_S = 3'd3, ALM_H = 3'd4, ALM_M = 3'd5
  } mode_e;

  localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

  mode_e      state_q, state_d;
  logic       inc_h_q, inc_h_d, inc_m_q, inc_m_d, inc_s_q, inc_s_d, clr_s_q, clr_s_d;
  logic [7:0] alm_hour_q, alm_hour_d, alm_minute_q, alm_minute_d;
  logic       alm_en_q, alm_en_d, alert_q, alert_d, match_q;
  logic [7:0] ring_q, ring_d;
  logic       in_set, match_c, trig, clr;

  // Illegal BCD codes fall back to 00 rather than propagating garbage.
  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    if (v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] > 4'd3) || v == 8'h23)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign in_set  = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);
  assign match_c = alm_en_q && (bus.hour == alm_hour_q) && (bus.minute == alm_minute_q)
                   && (bus.second == 8'h00);
  assign trig    = match_c && !match_q && !in_set;

  always_comb begin
    state_d      = state_q;
    inc_h_d      = 1'b0;
    inc_m_d      = 1'b0;
    clr_s_d      = 1'b0;
    alm_hour_d   = alm_hour_q;
    alm_minute_d = alm_minute_q;
    alm_en_d     = alm_en_q;
    inc_s_d      = bus.tick_1hz &&
                   ((state_q == RUN) || (state_q == ALM_H) || (state_q == ALM_M));

    if (state_q > ALM_M) begin
      state_d = RUN;
    end else if (bus.key_mode) begin
      case (state_q)
        RUN:                 state_d = SET_H;
        SET_H, SET_M, SET_S: state_d = ALM_H;
        default:             state_d = RUN;
      endcase
    end else if (bus.key_next) begin
      case (state_q)
        RUN:     alm_en_d = !alm_en_q;
        SET_H:   state_d  = SET_M;
        SET_M:   state_d  = SET_S;
        SET_S:   state_d  = SET_H;
        ALM_H:   state_d  = ALM_M;
        ALM_M:   state_d  = ALM_H;
        default: state_d  = RUN;
      endcase
    end else if (bus.key_inc) begin
      case (state_q)
        SET_H:   inc_h_d      = 1'b1;
        SET_M:   inc_m_d      = 1'b1;
        SET_S:   clr_s_d      = 1'b1;
        ALM_H:   alm_hour_d   = bcd_inc_hour(alm_hour_q);
        ALM_M:   alm_minute_d = bcd_inc_min(alm_minute_q);
        default: ;
      endcase
    end

    // Silencing wins over a trigger landing in the same cycle.
    clr     = bus.key_stop || (alm_en_q && !alm_en_d);
    alert_d = alert_q;
    ring_d  = ring_q;
    if (clr) begin
      alert_d = 1'b0;
      ring_d  = 8'd0;
    end else if (trig) begin
      alert_d = 1'b1;
      ring_d  = RING_LOAD;
    end else if (alert_q && bus.tick_1hz) begin
      ring_d  = ring_q - 8'd1;
      alert_d = (ring_q != 8'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      inc_h_q      <= 1'b0;
      inc_m_q      <= 1'b0;
      inc_s_q      <= 1'b0;
      clr_s_q      <= 1'b0;
      alm_hour_q   <= ALM_H_INIT;
      alm_minute_q <= ALM_M_INIT;
      alm_en_q     <= 1'b0;
      alert_q      <= 1'b0;
      ring_q       <= 8'd0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      inc_h_q      <= inc_h_d;
      inc_m_q      <= inc_m_d;
      inc_s_q      <= inc_s_d;
      clr_s_q      <= clr_s_d;
      alm_hour_q   <= alm_hour_d;
      alm_minute_q <= alm_minute_d;
      alm_en_q     <= alm_en_d;
      alert_q      <= alert_d;
      ring_q       <= ring_d;
      match_q      <= match_c;
    end
  end

  assign bus.inc_h      = inc_h_q;
  assign bus.inc_m      = inc_m_q;
  assign bus.inc_s      = inc_s_q;
  assign bus.clr_s      = clr_s_q;
  assign bus.alm_hour   = alm_hour_q;
  assign bus.alm_minute = alm_minute_q;
  assign bus.alm_en     = alm_en_q;
  assign bus.alert      = alert_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_clock_mode_ctrl;
  localparam int RING = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(.RING_SECS(RING), .ALM_H_INIT(8'h07), .ALM_M_INIT(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // k = {tick, stop, inc, next, mode}; held for exactly one cycle.
  task automatic drive(input logic [4:0] k);
    {bus.tick_1hz, bus.key_stop, bus.key_inc, bus.key_next, bus.key_mode} = k;
    @(negedge clk);
    {bus.tick_1hz, bus.key_stop, bus.key_inc, bus.key_next, bus.key_mode} = 5'b0;
  endtask

  localparam logic [4:0] K_MODE = 5'b00001, K_NEXT = 5'b00010, K_INC = 5'b00100,
                         K_STOP = 5'b01000, K_TICK = 5'b10000, K_NONE = 5'b00000;

  initial begin
    {bus.tick_1hz, bus.key_stop, bus.key_inc, bus.key_next, bus.key_mode} = 5'b0;
    bus.hour = 8'h12; bus.minute = 8'h34; bus.second = 8'h56;
    repeat (3) @(negedge clk);
    chk("rst_state", {5'b0, bus.state}, 8'd0);
    chk("rst_alm_hour", bus.alm_hour, 8'h07);
    chk("rst_alm_minute", bus.alm_minute, 8'h00);
    chk("rst_flags", {3'b0, bus.alm_en, bus.alert, bus.inc_s, bus.inc_h, bus.clr_s}, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      drive(K_TICK);
      chk("run_tick_inc_s", {7'b0, bus.inc_s}, 8'd1);
      drive(K_NONE);
      chk("run_inc_s_pulse", {7'b0, bus.inc_s}, 8'd0);
    end

    drive(K_MODE);
    chk("mode_set_h", {5'b0, bus.state}, 8'd1);
    for (int i = 0; i < 2; i++) begin
      drive(K_INC);
      chk("inc_h_pulse", {7'b0, bus.inc_h}, 8'd1);
      drive(K_NONE);
      chk("inc_h_low", {7'b0, bus.inc_h}, 8'd0);
    end
    drive(K_TICK);
    chk("set_tick_gated", {7'b0, bus.inc_s}, 8'd0);

    drive(K_NEXT);
    chk("next_set_m", {5'b0, bus.state}, 8'd2);
    drive(K_INC);
    chk("inc_m_pulse", {7'b0, bus.inc_m}, 8'd1);
    drive(K_NEXT);
    chk("next_set_s", {5'b0, bus.state}, 8'd3);
    drive(K_INC);
    chk("clr_s_pulse", {7'b0, bus.clr_s}, 8'd1);
    drive(K_NEXT);
    chk("next_wrap_set_h", {5'b0, bus.state}, 8'd1);
    drive(K_MODE);
    chk("mode_alm_h", {5'b0, bus.state}, 8'd4);
    drive(K_TICK);
    chk("alm_tick_inc_s", {7'b0, bus.inc_s}, 8'd1);

    repeat (16) drive(K_INC);
    chk("alm_hour_23", bus.alm_hour, 8'h23);
    drive(K_INC);
    chk("alm_hour_wrap", bus.alm_hour, 8'h00);
    repeat (7) drive(K_INC);
    chk("alm_hour_back", bus.alm_hour, 8'h07);

    drive(K_NEXT);
    chk("next_alm_m", {5'b0, bus.state}, 8'd5);
    repeat (9) drive(K_INC);
    chk("alm_min_09", bus.alm_minute, 8'h09);
    drive(K_INC);
    chk("alm_min_10", bus.alm_minute, 8'h10);
    repeat (49) drive(K_INC);
    chk("alm_min_59", bus.alm_minute, 8'h59);
    drive(K_INC);
    chk("alm_min_wrap", bus.alm_minute, 8'h00);

    drive(K_MODE);
    chk("mode_run", {5'b0, bus.state}, 8'd0);
    drive(K_MODE | K_INC);
    chk("prio_mode_state", {5'b0, bus.state}, 8'd1);
    chk("prio_no_inc_h", {7'b0, bus.inc_h}, 8'd0);
    drive(K_MODE);
    drive(K_MODE);
    chk("back_to_run", {5'b0, bus.state}, 8'd0);
    drive(K_NEXT);
    chk("alm_en_on", {7'b0, bus.alm_en}, 8'd1);

    // Alarm at 07:00 fires, then times out after RING ticks.
    bus.hour = 8'h07; bus.minute = 8'h00; bus.second = 8'h00;
    drive(K_NONE);
    chk("alert_trig", {7'b0, bus.alert}, 8'd1);
    bus.second = 8'h01;
    repeat (RING - 1) drive(K_TICK);
    chk("alert_still_on", {7'b0, bus.alert}, 8'd1);
    drive(K_TICK);
    chk("alert_timeout", {7'b0, bus.alert}, 8'd0);

    bus.second = 8'h00;
    drive(K_NONE);
    chk("retrig", {7'b0, bus.alert}, 8'd1);
    drive(K_STOP);
    chk("stop_clears", {7'b0, bus.alert}, 8'd0);

    bus.second = 8'h01;
    drive(K_NONE);
    bus.second = 8'h00;
    drive(K_NONE);
    chk("retrig2", {7'b0, bus.alert}, 8'd1);
    bus.second = 8'h01;
    drive(K_NONE);
    bus.second = 8'h00;
    drive(K_STOP);
    chk("stop_beats_trig", {7'b0, bus.alert}, 8'd0);
    drive(K_NONE);
    chk("no_late_trig", {7'b0, bus.alert}, 8'd0);

    bus.second = 8'h01;
    drive(K_NONE);
    bus.second = 8'h00;
    drive(K_NONE);
    chk("retrig3", {7'b0, bus.alert}, 8'd1);
    drive(K_NEXT);
    chk("alm_en_off", {7'b0, bus.alm_en}, 8'd0);
    chk("alm_off_clears", {7'b0, bus.alert}, 8'd0);

    bus.second = 8'h01;
    drive(K_NEXT);
    drive(K_MODE);
    chk("set_h_again", {5'b0, bus.state}, 8'd1);
    bus.second = 8'h00;
    drive(K_NONE);
    drive(K_NONE);
    chk("no_trig_in_set", {7'b0, bus.alert}, 8'd0);

    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", {5'b0, bus.state}, 8'd0);
    chk("async_rst_alm_en", {7'b0, bus.alm_en}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
